ddr3_sdram_model: RTL and testbench

- Synthesizable, single-rate behavioural DDR3 x16 SDRAM responder for SoC/PHY simulation.
- Decodes DDR3 commands, tracks per-bank open rows and mode registers, and stores write bursts in a small internal array.
- Returns read bursts after a programmable CAS latency.
- Sits on the controller's DRAM pin side. The bidirectional pins are split into in/out/oe. Data moves one beat per clock; true DDR timing is out of scope.

---
 rtl/ddr3_sdram_model.sv | 215 +++++++++++++++++++++
 tb/tb_ddr3_sdram_model.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ddr3_sdram_model.sv
// Single-rate behavioural DDR3 x16 responder: command decode, per-bank rows, mode regs, BL8 burst engine.
// Optional protocol checking is built when DDR3_PROTOCOL_CHECK_EN is defined; otherwise err is tied low.
module ddr3_sdram_model #(
  parameter int ADDR_W = 14,
  parameter int BA_W   = 3,
  parameter int DQ_W   = 16,
  parameter int MEM_AW = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cke,
  input  logic                cs_n,
  input  logic                ras_n,
  input  logic                cas_n,
  input  logic                we_n,
  input  logic [BA_W-1:0]     ba,
  input  logic [ADDR_W-1:0]   a,
  input  logic [DQ_W-1:0]     dq_in,
  input  logic [DQ_W/8-1:0]   dm,
  output logic [DQ_W-1:0]     dq_out,
  output logic                dq_oe,
  output logic                dqs_out,
  output logic                dqs_oe,
  output logic                mr_ready,
  output logic                err
);

  localparam int DM_W = DQ_W / 8;
  localparam int NB   = 1 << BA_W;
  localparam int DL_N = 16;

  typedef enum logic [2:0] {
    C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011,
    C_WR  = 3'b100, C_RD  = 3'b101, C_ZQ  = 3'b110, C_NOP = 3'b111
  } cmd_t;

  cmd_t                cmd;
  logic [3:0]          cl, cwl;
  logic [NB-1:0]       bank_open;
  logic [ADDR_W-1:0]   bank_row [NB];
  logic                bank_hit, rw_ok;
  logic [MEM_AW-1:0]   rw_addr;

  // Delay line: entry p was issued p+1 edges before the current edge
  logic                dl_vld  [DL_N];
  logic                dl_rd   [DL_N];
  logic [3:0]          dl_dly  [DL_N];
  logic [MEM_AW-1:0]   dl_addr [DL_N];

  logic                st_hit, st_rd, st_go, free;
  logic [MEM_AW-1:0]   st_addr;

  logic                pre_p0, pre_rd_p0;
  logic [MEM_AW-1:0]   pre_addr_p0;
  logic                act_p1, rd_p1;
  logic [2:0]          beat_p1;
  logic [MEM_AW-1:0]   base_p1;

  logic                nx_act, nx_rd;
  logic [2:0]          nx_beat;
  logic [MEM_AW-1:0]   nx_base, nx_word;

  logic [DQ_W-1:0]     mem [1 << MEM_AW];

  always_comb begin
    cmd      = (cs_n || !cke) ? C_NOP : cmd_t'({ras_n, cas_n, we_n});
    bank_hit = bank_open[ba];
    rw_ok    = (cmd == C_RD || cmd == C_WR) && bank_hit;
    rw_addr  = MEM_AW'({ba, bank_row[ba], a[9:0]});
  end

  // Start selection: an entry starts (preamble edge) when its age matches its captured latency-2
  always_comb begin
    st_hit  = 1'b0;
    st_rd   = 1'b0;
    st_addr = '0;
    for (int p = 0; p < DL_N; p++) begin
      if (dl_vld[p] && dl_dly[p] == 4'(p) && !st_hit) begin
        st_hit  = 1'b1;
        st_rd   = dl_rd[p];
        st_addr = dl_addr[p];
      end
    end
    // A new preamble may overlap the last beat of the running burst
    free  = !pre_p0 && (!act_p1 || beat_p1 >= 3'd6);
    st_go = st_hit && free;
  end

  always_comb begin
    nx_act  = 1'b0;
    nx_rd   = rd_p1;
    nx_beat = beat_p1;
    nx_base = base_p1;
    if (pre_p0) begin
      nx_act  = 1'b1;
      nx_rd   = pre_rd_p0;
      nx_beat = 3'd0;
      nx_base = pre_addr_p0;
    end else if (act_p1 && beat_p1 != 3'd7) begin
      nx_act  = 1'b1;
      nx_beat = beat_p1 + 3'd1;
    end
    nx_word = {nx_base[MEM_AW-1:3], nx_base[2:0] + nx_beat};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cl          <= 4'd5;
      cwl         <= 4'd5;
      mr_ready    <= 1'b0;
      bank_open   <= '0;
      for (int b = 0; b < NB; b++) bank_row[b] <= '0;
      for (int p = 0; p < DL_N; p++) begin
        dl_vld[p]  <= 1'b0;
        dl_rd[p]   <= 1'b0;
        dl_dly[p]  <= '0;
        dl_addr[p] <= '0;
      end
      pre_p0      <= 1'b0;
      pre_rd_p0   <= 1'b0;
      pre_addr_p0 <= '0;
      act_p1      <= 1'b0;
      rd_p1       <= 1'b0;
      beat_p1     <= '0;
      base_p1     <= '0;
      dq_out      <= '0;
      dq_oe       <= 1'b0;
      dqs_out     <= 1'b0;
      dqs_oe      <= 1'b0;
    end else begin
      case (cmd)
        C_MRS: begin
          if (ba == BA_W'(0)) begin
            mr_ready <= 1'b1;
            if (a[6:4] != 3'd0) cl <= 4'(a[6:4]) + 4'd4;
          end else if (ba == BA_W'(2)) begin
            cwl <= 4'(a[5:3]) + 4'd5;
          end
        end
        C_ACT: begin
          bank_open[ba] <= 1'b1;
          bank_row[ba]  <= a;
        end
        C_PRE: begin
          if (a[10]) bank_open <= '0;
          else       bank_open[ba] <= 1'b0;
        end
        C_RD, C_WR: begin
          if (bank_hit && a[10]) bank_open[ba] <= 1'b0;
        end
        default: ;
      endcase

      // Stage p0: issue into the delay line with latency captured now
      dl_vld[0]  <= rw_ok;
      dl_rd[0]   <= (cmd == C_RD);
      dl_dly[0]  <= ((cmd == C_RD) ? cl : cwl) - 4'd2;
      dl_addr[0] <= rw_addr;
      for (int p = 1; p < DL_N; p++) begin
        dl_vld[p]  <= dl_vld[p-1];
        dl_rd[p]   <= dl_rd[p-1];
        dl_dly[p]  <= dl_dly[p-1];
        dl_addr[p] <= dl_addr[p-1];
      end

      pre_p0 <= st_go;
      if (st_go) begin
        pre_rd_p0   <= st_rd;
        pre_addr_p0 <= st_addr;
      end

      // Stage p1: data beats
      act_p1  <= nx_act;
      rd_p1   <= nx_rd;
      beat_p1 <= nx_beat;
      base_p1 <= nx_base;
      dq_oe   <= nx_act && nx_rd;
      dq_out  <= (nx_act && nx_rd) ? mem[nx_word] : '0;
      dqs_oe  <= (nx_act && nx_rd) || (st_go && st_rd);
      dqs_out <= nx_act && nx_rd && !nx_beat[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && nx_act && !nx_rd) begin
      for (int i = 0; i < DM_W; i++)
        if (!dm[i]) mem[nx_word][8*i +: 8] <= dq_in[8*i +: 8];
    end
  end

`ifdef DDR3_PROTOCOL_CHECK_EN
  logic       proto_bad;
  logic [4:0] st_n;

  always_comb begin
    st_n = '0;
    for (int p = 0; p < DL_N; p++)
      if (dl_vld[p] && dl_dly[p] == 4'(p)) st_n = st_n + 5'd1;
    proto_bad = (cmd == C_ACT && bank_hit)
             || ((cmd == C_RD || cmd == C_WR) && !bank_hit)
             || (cmd == C_REF && |bank_open)
             || (st_n > 5'd1) || (st_n == 5'd1 && !free)
             || (cmd == C_MRS && ba == BA_W'(0) && a[6:4] == 3'd0)
             || (!mr_ready && !(cmd == C_MRS || cmd == C_NOP || cmd == C_ZQ));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            err <= 1'b0;
    else if (proto_bad) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ddr3_sdram_model.sv
// Directed bench for ddr3_sdram_model: reset, MRS, write/read with mask and wrap, drops, mid-burst reset.
module tb_ddr3_sdram_model;

  logic        clk = 1'b0, rst = 1'b1, cke = 1'b1;
  logic        cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [2:0]  ba = '0;
  logic [13:0] a = '0;
  logic [15:0] dq_in = '0;
  logic [1:0]  dm = '0;
  logic [15:0] dq_out;
  logic        dq_oe, dqs_out, dqs_oe, mr_ready, err;

  int tot = 0;
  int bad = 0;
  logic [15:0] expd [16];

`ifdef DDR3_PROTOCOL_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  localparam logic [2:0] MRS = 3'b000, ACT = 3'b011, WR = 3'b100, RD = 3'b101;

  ddr3_sdram_model dut (
    .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .ba(ba), .a(a), .dq_in(dq_in), .dm(dm), .dq_out(dq_out), .dq_oe(dq_oe),
    .dqs_out(dqs_out), .dqs_oe(dqs_oe), .mr_ready(mr_ready), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send(input logic [2:0] c, input logic [2:0] b, input logic [13:0] ad);
    cs_n = 1'b0; {ras_n, cas_n, we_n} = c; ba = b; a = ad;
    @(negedge clk);
    cs_n = 1'b1; {ras_n, cas_n, we_n} = 3'b111; ba = '0; a = '0;
  endtask

  // Write burst with CWL=5; beat i carries base+i, dm0 applies to beat 0 only
  task automatic wr_burst(input logic [2:0] b, input logic [13:0] col,
                          input logic [15:0] base, input logic [1:0] dm0);
    send(WR, b, col);
    repeat (4) step();
    for (int i = 0; i < 8; i++) begin
      dq_in = base + 16'(i);
      dm    = (i == 0) ? dm0 : 2'b00;
      step();
    end
    dq_in = '0;
    dm    = '0;
  endtask

  // Called just after the edge of the first command (k=0); checks cycles k0+1..k1
  task automatic watch(input int cl, input int nb, input int k0, input int k1);
    logic on, pre;
    for (int k = k0 + 1; k <= k1; k++) begin
      step();
      on  = (nb > 0) && (k >= cl) && (k <= cl + 8*nb - 1);
      pre = (nb > 0) && (k >= cl - 1) && (k <= cl + 8*nb - 1);
      chk($sformatf("dq_oe k=%0d", k), 32'(dq_oe), 32'(on));
      chk($sformatf("dqs_oe k=%0d", k), 32'(dqs_oe), 32'(pre));
      chk($sformatf("dq_out k=%0d", k), 32'(dq_out), on ? 32'(expd[k-cl]) : 32'd0);
      chk($sformatf("dqs_out k=%0d", k), 32'(dqs_out), 32'(on && ((k - cl) % 2 == 0)));
    end
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst dq_oe", 32'(dq_oe), 32'd0);
    chk("rst dqs_oe", 32'(dqs_oe), 32'd0);
    chk("rst dq_out", 32'(dq_out), 32'd0);
    chk("rst dqs_out", 32'(dqs_out), 32'd0);
    chk("rst mr_ready", 32'(mr_ready), 32'd0);
    chk("rst err", 32'(err), 32'd0);

    send(MRS, 3'd0, 14'h020);
    chk("mrs mr_ready", 32'(mr_ready), 32'd1);
    send(ACT, 3'd1, 14'd5);

    wr_burst(3'd1, 14'd0, 16'h1000, 2'b00);
    for (int i = 0; i < 8; i++) expd[i] = 16'h1000 + 16'(i);
    send(RD, 3'd1, 14'd0);
    watch(6, 1, 0, 15);

    wr_burst(3'd1, 14'd3, 16'hA0B0, 2'b01);
    expd[0] = 16'hA003;
    for (int i = 1; i < 8; i++) expd[i] = 16'hA0B0 + 16'(i);
    send(RD, 3'd1, 14'd3);
    watch(6, 1, 0, 15);
    chk("err before closed rd", 32'(err), 32'd0);

    send(RD, 3'd2, 14'd0);
    watch(6, 0, 0, 14);
    chk("err closed rd", 32'(err), 32'(CHK));

    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    chk("err after rst", 32'(err), 32'd0);
    chk("mr_ready after rst", 32'(mr_ready), 32'd0);
    send(MRS, 3'd0, 14'h020);
    send(ACT, 3'd1, 14'd5);

    expd[0] = 16'hA0B5; expd[1] = 16'hA0B6; expd[2] = 16'hA0B7; expd[3] = 16'hA003;
    expd[4] = 16'hA0B1; expd[5] = 16'hA0B2; expd[6] = 16'hA0B3; expd[7] = 16'hA0B4;
    send(RD, 3'd1, 14'd0);
    repeat (3) step();
    send(RD, 3'd1, 14'd0);
    watch(6, 1, 4, 20);
    chk("err dropped burst", 32'(err), 32'(CHK));

    send(RD, 3'd1, 14'd0);
    repeat (7) step();
    chk("mid burst dq_oe", 32'(dq_oe), 32'd1);
    rst = 1'b1;
    #1;
    chk("async rst dq_oe", 32'(dq_oe), 32'd0);
    chk("async rst dqs_oe", 32'(dqs_oe), 32'd0);
    chk("async rst dq_out", 32'(dq_out), 32'd0);
    step();
    rst = 1'b0;
    send(RD, 3'd1, 14'd0);
    watch(5, 0, 0, 12);

    send(ACT, 3'd1, 14'd5);
    for (int i = 0; i < 8; i++) expd[i+8] = expd[i];
    send(RD, 3'd1, 14'd0);
    repeat (7) step();
    send(RD, 3'd1, 14'd0);
    watch(5, 2, 8, 22);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
